// File: rtl/sme_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sme_pkg: shared sizes, loader state encoding and special characters   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sme_pkg;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SEND_S = 3'd3,
    ST_SEND_P = 3'd4,
    ST_WAIT   = 3'd5,
    ST_RESULT = 3'd6
  } ldr_state_t;

  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage
`default_nettype wire

// File: rtl/sme_job_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sme_job_loader_if: host byte stream, engine strobes and result bus    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sme_job_loader_if;
  import sme_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_tag;
  logic       in_last;

  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_index;

  logic       res_valid;
  logic       res_ready;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic       res_timeout;

  modport slave (
    input  in_valid, in_data, in_tag, in_last,
    input  sme_valid, sme_match, sme_index, res_ready,
    output in_ready, chardata, isstring, ispattern,
    output res_valid, res_match, res_index, res_err, res_timeout
  );

  modport master (
    output in_valid, in_data, in_tag, in_last,
    output sme_valid, sme_match, sme_index, res_ready,
    input  in_ready, chardata, isstring, ispattern,
    input  res_valid, res_match, res_index, res_err, res_timeout
  );

endinterface
`default_nettype wire

// File: rtl/sme_byte_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sme_byte_buf: byte buffer, synchronous write, combinational read      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sme_byte_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire          clk,
  input  wire          i_we,
  input  wire [AW-1:0] i_waddr,
  input  wire [7:0]    i_wdata,
  input  wire [AW-1:0] i_raddr,
  output logic [7:0]   o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sme_job_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sme_job_loader: buffers one string/pattern job, replays it to the     |
// | engine, returns the result. Option macro: SME_LOADER_TIMEOUT_EN       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sme_job_loader
  import sme_pkg::*;
#(
  parameter int STR_MAX = sme_pkg::STR_MAX,
  parameter int PAT_MAX = sme_pkg::PAT_MAX
`ifdef SME_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input wire              clk,
  input wire              reset,
  sme_job_loader_if.slave bus
);

  localparam int SW  = $clog2(STR_MAX + 1);
  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int SIW = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);

  ldr_state_t     r_state, w_state_nxt;
  logic [SW-1:0]  r_ns, w_ns_nxt;
  logic [PW-1:0]  r_np, w_np_nxt;
  logic [SIW-1:0] r_sidx, w_sidx_nxt;
  logic [PIW-1:0] r_pidx, w_pidx_nxt;

  logic       w_accept, w_bad_byte, w_str_we, w_pat_we, w_char_bypass;
  logic       w_enter_result;
  logic [7:0] w_str_rd, w_pat_rd, w_char_nxt;

  logic       r_in_ready, r_isstring, r_ispattern;
  logic [7:0] r_chardata;
  logic       r_res_valid, r_res_match, r_res_err;
  logic [4:0] r_res_index;

`ifdef SME_LOADER_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_res_timeout;
  logic       w_wd_expired;
  assign w_wd_expired = (r_wd == 8'(TIMEOUT_CYC - 1));
`endif

  sme_byte_buf #(.DEPTH(STR_MAX), .AW(SIW)) u_str_buf (
    .clk     (clk),
    .i_we    (w_str_we),
    .i_waddr (r_ns[SIW-1:0]),
    .i_wdata (bus.in_data),
    .i_raddr (w_sidx_nxt),
    .o_rdata (w_str_rd)
  );

  sme_byte_buf #(.DEPTH(PAT_MAX), .AW(PIW)) u_pat_buf (
    .clk     (clk),
    .i_we    (w_pat_we),
    .i_waddr (r_np[PIW-1:0]),
    .i_wdata (bus.in_data),
    .i_raddr (w_pidx_nxt),
    .o_rdata (w_pat_rd)
  );

  assign w_accept = bus.in_valid && r_in_ready;

  // Order violation only needs r_np: a rejected tag-1 byte already errors the job.
  assign w_bad_byte = bus.in_tag ? (r_np == PW'(PAT_MAX))
                                 : ((r_np != '0) || (r_ns == SW'(STR_MAX)));

  always_comb begin
    w_state_nxt   = r_state;
    w_ns_nxt      = r_ns;
    w_np_nxt      = r_np;
    w_sidx_nxt    = r_sidx;
    w_pidx_nxt    = r_pidx;
    w_str_we      = 1'b0;
    w_pat_we      = 1'b0;
    w_char_bypass = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_accept) begin
          if (!w_bad_byte) begin
            if (bus.in_tag) begin
              w_pat_we = 1'b1;
              w_np_nxt = r_np + PW'(1);
            end else begin
              w_str_we = 1'b1;
              w_ns_nxt = r_ns + SW'(1);
            end
          end
          if (bus.in_last) begin
            // A tag-0 last byte is always bad: either no pattern or out of order.
            if (w_bad_byte || !bus.in_tag) begin
              w_state_nxt = ST_RESULT;
            end else if (r_ns != '0) begin
              w_state_nxt = ST_SEND_S;
              w_sidx_nxt  = '0;
            end else begin
              w_state_nxt   = ST_SEND_P;
              w_pidx_nxt    = '0;
              w_char_bypass = (r_np == '0);
            end
          end else if (w_bad_byte) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (w_accept && bus.in_last) w_state_nxt = ST_RESULT;
      end
      ST_SEND_S: begin
        if (SW'(r_sidx) == r_ns - SW'(1)) begin
          w_state_nxt = ST_SEND_P;
          w_pidx_nxt  = '0;
        end else begin
          w_sidx_nxt = r_sidx + SIW'(1);
        end
      end
      ST_SEND_P: begin
        if (PW'(r_pidx) == r_np - PW'(1)) w_state_nxt = ST_WAIT;
        else                               w_pidx_nxt  = r_pidx + PIW'(1);
      end
      ST_WAIT: begin
        if (bus.sme_valid) w_state_nxt = ST_RESULT;
`ifdef SME_LOADER_TIMEOUT_EN
        else if (w_wd_expired) w_state_nxt = ST_RESULT;
`endif
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          w_state_nxt = ST_IDLE;
          w_ns_nxt    = '0;
          w_np_nxt    = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The only pattern byte not yet in the buffer is a single-byte job's first byte.
  assign w_char_nxt = (w_state_nxt == ST_SEND_S) ? w_str_rd :
                      (w_state_nxt == ST_SEND_P) ? (w_char_bypass ? bus.in_data : w_pat_rd) :
                      8'h00;

  assign w_enter_result = (w_state_nxt == ST_RESULT) && (r_state != ST_RESULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ns    <= '0;
      r_np    <= '0;
      r_sidx  <= '0;
      r_pidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ns    <= w_ns_nxt;
      r_np    <= w_np_nxt;
      r_sidx  <= w_sidx_nxt;
      r_pidx  <= w_pidx_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_chardata  <= 8'h00;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= 5'd0;
      r_res_err   <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                     (w_state_nxt == ST_DRAIN);
      r_chardata  <= w_char_nxt;
      r_isstring  <= (w_state_nxt == ST_SEND_S);
      r_ispattern <= (w_state_nxt == ST_SEND_P);
      if (w_enter_result) begin
        r_res_valid <= 1'b1;
        r_res_err   <= (r_state != ST_WAIT);
        r_res_match <= (r_state == ST_WAIT) && bus.sme_valid && bus.sme_match;
        r_res_index <= ((r_state == ST_WAIT) && bus.sme_valid) ? bus.sme_index : 5'd0;
      end else if ((r_state == ST_RESULT) && bus.res_ready) begin
        r_res_valid <= 1'b0;
        r_res_err   <= 1'b0;
        r_res_match <= 1'b0;
        r_res_index <= 5'd0;
      end
    end
  end

`ifdef SME_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd          <= 8'd0;
      r_res_timeout <= 1'b0;
    end else begin
      r_wd <= ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) ? r_wd + 8'd1 : 8'd0;
      if (w_enter_result)
        r_res_timeout <= (r_state == ST_WAIT) && !bus.sme_valid;
      else if ((r_state == ST_RESULT) && bus.res_ready)
        r_res_timeout <= 1'b0;
    end
  end
  assign bus.res_timeout = r_res_timeout;
`else
  assign bus.res_timeout = 1'b0;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.chardata  = r_chardata;
  assign bus.isstring  = r_isstring;
  assign bus.ispattern = r_ispattern;
  assign bus.res_valid = r_res_valid;
  assign bus.res_match = r_res_match;
  assign bus.res_index = r_res_index;
  assign bus.res_err   = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_sme_job_loader.sv
`default_nettype none
// tb_sme_job_loader: directed, self-checking bench for sme_job_loader.
module tb_sme_job_loader;
  import sme_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sme_job_loader_if bus();

  sme_job_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int t_rv     = 0;
  int stall_cnt = 0;

  int s_cnt, p_cnt, s_first, s_last, p_first, p_last, both_cnt;
  logic [7:0] s_bytes [64];
  logic [7:0] p_bytes [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.isstring) begin
      if (s_cnt == 0) s_first = cyc;
      s_last = cyc;
      if (s_cnt < 64) s_bytes[s_cnt] = bus.chardata;
      s_cnt++;
    end
    if (bus.ispattern) begin
      if (p_cnt == 0) p_first = cyc;
      p_last = cyc;
      if (p_cnt < 16) p_bytes[p_cnt] = bus.chardata;
      p_cnt++;
    end
    if (bus.isstring && bus.ispattern) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    s_cnt = 0; p_cnt = 0; s_first = -1; s_last = -1;
    p_first = -1; p_last = -1; both_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic t, input logic l);
    int k = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_tag = t; bus.in_last = l;
    while (!bus.in_ready && k < 100) begin
      stall_cnt++;
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) check_val("in_ready_wait", 32'(bus.in_ready), 32'd1);
    t_acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_tag = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_string(input string s, input logic t, input logic last_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], t, last_end && (i == s.len() - 1));
  endtask

  task automatic wait_send_done();
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.isstring || bus.ispattern) seen = 1'b1;
      else if (seen) return;
      @(negedge clk);
    end
    check_val("send_done_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_res(input int limit);
    for (int k = 0; k < limit; k++) begin
      if (bus.res_valid) begin
        t_rv = cyc;
        return;
      end
      @(negedge clk);
    end
    t_rv = -1;
    check_val("res_valid_wait", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic engine_reply(input logic m, input logic [4:0] idx);
    bus.sme_valid = 1'b1; bus.sme_match = m; bus.sme_index = idx;
    @(negedge clk);
    bus.sme_valid = 1'b0; bus.sme_match = 1'b0; bus.sme_index = 5'd0;
  endtask

  task automatic check_result(input string tag, input logic m, input logic [4:0] idx,
                              input logic err, input logic to);
    check_val({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check_val({tag, "_res_fields"},
              32'({bus.res_match, bus.res_index, bus.res_err, bus.res_timeout}),
              32'({m, idx, err, to}));
  endtask

  task automatic consume(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_val({tag, "_ready_after"}, 32'({bus.in_ready, bus.res_valid}), 32'b10);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    int bad;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_tag = 1'b0; bus.in_last = 1'b0;
    bus.sme_valid = 1'b0; bus.sme_match = 1'b0; bus.sme_index = 5'd0; bus.res_ready = 1'b0;
    mon_clear();

    // Reset values and in_ready rising one edge after release
    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              32'({bus.in_ready, bus.chardata, bus.isstring, bus.ispattern, bus.res_valid,
                   bus.res_match, bus.res_index, bus.res_err, bus.res_timeout}), 32'd0);
    reset = 1'b0;
    #1 check_val("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_val("in_ready_after_edge", 32'(bus.in_ready), 32'd1);

    // Stray engine strobe while idle is ignored
    engine_reply(1'b1, 5'd9);
    check_val("stray_sme_valid", 32'({bus.res_valid, bus.in_ready}), 32'b01);

    // Job 1: "ABC DEF" + "DE"
    mon_clear();
    send_string("ABC DEF", 1'b0, 1'b0);
    send_string("DE", 1'b1, 1'b1);
    wait_send_done();
    check_val("j1_s_cnt", 32'(s_cnt), 32'd7);
    check_val("j1_p_cnt", 32'(p_cnt), 32'd2);
    check_val("j1_first_strobe", 32'(s_first), 32'(t_acc + 1));
    check_val("j1_no_gap", 32'(p_first), 32'(s_last + 1));
    check_val("j1_duration", 32'(p_last - s_first + 1), 32'd9);
    check_val("j1_overlap", 32'(both_cnt), 32'd0);
    check_val("j1_str_bytes", {s_bytes[0], s_bytes[3], s_bytes[6]}, {8'h41, CH_SPACE, 8'h46});
    check_val("j1_pat_bytes", {p_bytes[0], p_bytes[1]}, {8'h44, 8'h45});
    check_val("j1_idle_char", 32'({bus.chardata, bus.in_ready}), 32'd0);
    engine_reply(1'b1, 5'd4);
    check_result("j1", 1'b1, 5'd4, 1'b0, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_match !== 1'b1 || bus.res_index !== 5'd4 ||
          bus.res_err !== 1'b0 || bus.in_ready !== 1'b0) bad++;
    end
    check_val("j1_hold_stable", 32'(bad), 32'd0);
    consume("j1");

    // Job 2: pattern-only "^D"
    mon_clear();
    send_byte(CH_CARET, 1'b1, 1'b0);
    send_byte(8'h44, 1'b1, 1'b1);
    wait_send_done();
    check_val("j2_counts", {16'(s_cnt), 16'(p_cnt)}, {16'd0, 16'd2});
    check_val("j2_first_strobe", 32'(p_first), 32'(t_acc + 1));
    check_val("j2_pat_bytes", {p_bytes[0], p_bytes[1]}, {CH_CARET, 8'h44});
    engine_reply(1'b1, 5'd2);
    check_result("j2", 1'b1, 5'd2, 1'b0, 1'b0);
    consume("j2");

    // Job 3: single pattern byte, first byte is also last
    mon_clear();
    send_byte(8'h58, 1'b1, 1'b1);
    wait_send_done();
    check_val("j3_counts", {16'(s_cnt), 16'(p_cnt)}, {16'd0, 16'd1});
    check_val("j3_first_strobe", 32'(p_first), 32'(t_acc + 1));
    check_val("j3_pat_byte", 32'(p_bytes[0]), 32'h58);
    engine_reply(1'b0, 5'd17);
    check_result("j3", 1'b0, 5'd17, 1'b0, 1'b0);
    consume("j3");

    // Job 4: full buffers, 32 string + 8 pattern bytes
    mon_clear();
    for (int i = 0; i < 32; i++) send_byte(8'(8'h61 + (i % 26)), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b1, i == 7);
    wait_send_done();
    check_val("j4_counts", {16'(s_cnt), 16'(p_cnt)}, {16'd32, 16'd8});
    check_val("j4_duration", 32'(p_last - s_first + 1), 32'd40);
    check_val("j4_edge_bytes", {s_bytes[0], s_bytes[31], p_bytes[7]}, {8'h61, 8'h66, 8'h37});
    engine_reply(1'b1, 5'd31);
    check_result("j4", 1'b1, 5'd31, 1'b0, 1'b0);
    consume("j4");

    // Job 5: 33 string bytes overflow, drained until last
    mon_clear();
    stall_cnt = 0;
    for (int i = 0; i < 33; i++) send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b1);
    wait_res(20);
    check_val("j5_latency", 32'(t_rv), 32'(t_acc + 1));
    check_val("j5_no_stall", 32'(stall_cnt), 32'd0);
    check_val("j5_no_strobe", 32'(s_cnt + p_cnt), 32'd0);
    check_result("j5", 1'b0, 5'd0, 1'b1, 1'b0);
    consume("j5");

    // Job 6: string byte after a pattern byte
    mon_clear();
    send_string("AB", 1'b0, 1'b0);
    send_string("C", 1'b1, 1'b0);
    send_string("D", 1'b0, 1'b1);
    wait_res(20);
    check_val("j6_latency", 32'(t_rv), 32'(t_acc + 1));
    check_result("j6", 1'b0, 5'd0, 1'b1, 1'b0);
    consume("j6");

    // Job 7: 9 pattern bytes
    send_string("A", 1'b0, 1'b0);
    send_string("123456789", 1'b1, 1'b1);
    wait_res(20);
    check_result("j7", 1'b0, 5'd0, 1'b1, 1'b0);
    consume("j7");

    // Job 8: last byte with no pattern at all
    send_string("AB", 1'b0, 1'b1);
    wait_res(20);
    check_val("j8_latency", 32'(t_rv), 32'(t_acc + 1));
    check_val("j8_no_strobe", 32'(s_cnt + p_cnt), 32'd0);
    check_result("j8", 1'b0, 5'd0, 1'b1, 1'b0);
    consume("j8");

    // Job 9: engine silent
    mon_clear();
    send_string("Q", 1'b0, 1'b0);
    send_string("Q", 1'b1, 1'b1);
    wait_send_done();
`ifdef SME_LOADER_TIMEOUT_EN
    wait_res(400);
    check_val("j9_timeout_latency", 32'(t_rv), 32'(p_last + 256));
    check_result("j9", 1'b0, 5'd0, 1'b0, 1'b1);
`else
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) bad++;
    end
    check_val("j9_wait_holds", 32'(bad), 32'd0);
    engine_reply(1'b1, 5'd1);
    check_result("j9", 1'b1, 5'd1, 1'b0, 1'b0);
`endif
    consume("j9");

    // Job 10: reset in the middle of the string burst
    mon_clear();
    for (int i = 0; i < 10; i++) send_byte(8'h4B, 1'b0, 1'b0);
    send_byte(8'h4C, 1'b1, 1'b1);
    @(negedge clk);
    check_val("j10_in_send", 32'(bus.isstring), 32'd1);
    reset = 1'b1;
    #1 check_val("j10_reset_outputs",
                 32'({bus.in_ready, bus.chardata, bus.isstring, bus.ispattern, bus.res_valid,
                      bus.res_match, bus.res_index, bus.res_err, bus.res_timeout}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("j10_recover", 32'({bus.in_ready, bus.isstring, bus.ispattern}), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
